// File: rtl/nibble_sequencer.sv
// Fetch/decode/execute control unit for the 4-bit accumulator datapath.
// Define SEQ_SINGLE_STEP_EN to add the step input (one instruction per pulse).
module nibble_sequencer #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          resetA,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          CARRY,
  input  logic          ZERO,
  output logic [2:0]    F,
  output logic [3:0]    OPRND,
  output logic          enableA,
  output logic          enableB1,
  output logic          enableB2,
  output logic          halted
);

  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_NAND = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_JNZ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'h9;

  localparam logic [2:0] FN_OUT  = 3'b000;
  localparam logic [2:0] FN_SUB  = 3'b001;
  localparam logic [2:0] FN_LIT  = 3'b010;
  localparam logic [2:0] FN_ADD  = 3'b011;
  localparam logic [2:0] FN_NAND = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_JADDR,
    S_JLOAD,
    S_HALT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] pc_inc;
  logic [3:0]    ir;
  logic [3:0]    ir_nxt;
  logic [2:0]    f_nxt;
  logic [3:0]    oprnd_nxt;
  logic [3:0]    op_d;
  logic          jump_d;
  logic          alu_x;
  logic          take;
  logic          go;

`ifdef SEQ_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  assign rom_addr = pc;
  assign pc_inc   = pc + AW'(1);
  assign op_d     = rom_data[7:4];
  assign jump_d   = op_d inside {OP_JMP, OP_JC, OP_JNZ};
  assign alu_x    = ir inside {OP_LIT, OP_SUB, OP_ADD, OP_NAND};

  // Opcodes without an ALU function leave F untouched.
  function automatic logic [2:0] alu_f(
    input logic [3:0] op,
    input logic [2:0] held
  );
    unique case (op)
      OP_LIT:  return FN_LIT;
      OP_SUB:  return FN_SUB;
      OP_ADD:  return FN_ADD;
      OP_NAND: return FN_NAND;
      OP_OUT:  return FN_OUT;
      default: return held;
    endcase
  endfunction

  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      (ir == OP_JMP): take = 1'b1;
      (ir == OP_JC):  take = CARRY;
      (ir == OP_JNZ): take = !ZERO;
      default:        take = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    f_nxt     = F;
    oprnd_nxt = OPRND;
    enableA   = 1'b0;
    enableB1  = 1'b0;
    enableB2  = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (go) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ir_nxt = op_d;
        pc_nxt = pc_inc;
        unique case (1'b1)
          jump_d:
            state_nxt = S_JADDR;
          (op_d == OP_HALT):
            state_nxt = S_HALT;
          default: begin
            state_nxt = S_EXEC;
            oprnd_nxt = rom_data[3:0];
            f_nxt     = alu_f(op_d, F);
          end
        endcase
      end
      S_EXEC: begin
        enableA   = alu_x;
        enableB1  = alu_x;
        enableB2  = (ir == OP_OUT);
        state_nxt = S_FETCH;
      end
      S_JADDR: begin
        state_nxt = S_JLOAD;
      end
      S_JLOAD: begin
        // Not taken: skip over the target byte.
        pc_nxt    = take ? rom_data[AW-1:0] : pc_inc;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetA) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      F     <= '0;
      OPRND <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      F     <= f_nxt;
      OPRND <= oprnd_nxt;
    end
  end

endmodule

// File: tb/tb_nibble_sequencer.sv
// Bench for nibble_sequencer: AW=8 and AW=4 instances against an
// instruction-level reference interpreter, plus directed program checks.
module tb_nibble_sequencer;

  localparam int NMAX = 1024;

  logic       clk = 1'b0;
  logic       resetA = 1'b0;
  logic       CARRY = 1'b0;
  logic       ZERO = 1'b0;
  logic [7:0] addr8;
  logic [3:0] addr4;
  logic [7:0] rd8 = 8'h00;
  logic [7:0] rd4 = 8'h00;
  logic [7:0] rom8 [256];
  logic [7:0] rom4 [16];

  logic [2:0] f8, f4;
  logic [3:0] o8, o4;
  logic       ea8, eb1_8, eb2_8, h8;
  logic       ea4, eb1_4, eb2_4, h4;

`ifdef SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd8 <= rom8[addr8];
    rd4 <= rom4[addr4];
  end

  nibble_sequencer #(.AW(8)) dut8 (
    .clk(clk),
    .resetA(resetA),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .rom_addr(addr8),
    .rom_data(rd8),
    .CARRY(CARRY),
    .ZERO(ZERO),
    .F(f8),
    .OPRND(o8),
    .enableA(ea8),
    .enableB1(eb1_8),
    .enableB2(eb2_8),
    .halted(h8)
  );

  nibble_sequencer #(.AW(4)) dut4 (
    .clk(clk),
    .resetA(resetA),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .rom_addr(addr4),
    .rom_data(rd4),
    .CARRY(CARRY),
    .ZERO(ZERO),
    .F(f4),
    .OPRND(o4),
    .enableA(ea4),
    .enableB1(eb1_4),
    .enableB2(eb2_4),
    .halted(h4)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Row layout: {halted, enB2, enB1, enA, F[2:0], OPRND[3:0], addr[7:0]}
  function automatic logic [18:0] pack8();
    return {h8, eb2_8, eb1_8, ea8, f8, o8, addr8};
  endfunction

  function automatic logic [18:0] pack4();
    return {h4, eb2_4, eb1_4, ea4, f4, o4, 4'h0, addr4};
  endfunction

  logic        cy [NMAX];
  logic        zr [NMAX];
  logic [7:0]  prog [256];
  logic [18:0] exp_tr [NMAX];
  logic [18:0] exp8 [NMAX];
  logic [18:0] exp4 [NMAX];
  logic [18:0] obs8 [NMAX];
  logic [18:0] obs4 [NMAX];
  int          mc;

  function automatic logic [18:0] row(input int a, input logic [2:0] f,
                                      input logic [3:0] o,
                                      input logic [2:0] en,
                                      input logic h);
    logic [7:0] a8;
    a8 = 8'(a);
    return {h, en, f, o, a8};
  endfunction

  task automatic emit(input int n, input int a, input logic [2:0] f,
                      input logic [3:0] o, input logic [2:0] en,
                      input logic h);
    if (mc < n) exp_tr[mc] = row(a, f, o, en, h);
    mc++;
  endtask

  // Interprets prog instruction by instruction, emitting one row per cycle.
  task automatic model(input int aw, input int n);
    int m, pc, ins, opc, t;
    logic [2:0] f, en;
    logic [3:0] o;
    logic tk;
    m = 1 << aw;
    pc = 0;
    f = 3'b000;
    o = 4'h0;
    mc = 0;
    while (mc < n) begin
      emit(n, pc, f, o, 3'b000, 1'b0);
      ins = int'(prog[pc]);
      emit(n, pc, f, o, 3'b000, 1'b0);
      pc = (pc + 1) % m;
      opc = ins >> 4;
      if (opc >= 6 && opc <= 8) begin
        emit(n, pc, f, o, 3'b000, 1'b0);
        t = int'(prog[pc]) % m;
        tk = (opc == 6) ||
             (opc == 7 && mc < NMAX && cy[mc] === 1'b1) ||
             (opc == 8 && mc < NMAX && zr[mc] === 1'b0);
        emit(n, pc, f, o, 3'b000, 1'b0);
        pc = tk ? t : (pc + 1) % m;
      end else if (opc == 9) begin
        while (mc < n) emit(n, pc, f, o, 3'b000, 1'b1);
      end else begin
        o = 4'(ins & 15);
        en = 3'b000;
        case (opc)
          1: begin f = 3'b010; en = 3'b011; end
          2: begin f = 3'b001; en = 3'b011; end
          3: begin f = 3'b011; en = 3'b011; end
          4: begin f = 3'b100; en = 3'b011; end
          5: begin f = 3'b000; en = 3'b100; end
          default: ;
        endcase
        emit(n, pc, f, o, en, 1'b0);
      end
    end
  endtask

  task automatic apply(input int n);
    for (int i = 0; i < 256; i++) prog[i] = rom8[i];
    model(8, n);
    for (int i = 0; i < n; i++) exp8[i] = exp_tr[i];
    for (int i = 0; i < 256; i++) prog[i] = (i < 16) ? rom4[i] : 8'h00;
    model(4, n);
    for (int i = 0; i < n; i++) exp4[i] = exp_tr[i];
    @(negedge clk);
    resetA = 1'b0;
    CARRY = 1'b0;
    ZERO = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset8", 32'(pack8()), 32'd0);
    chk("reset4", 32'(pack4()), 32'd0);
    resetA = 1'b1;
    for (int k = 0; k < n; k++) begin
      obs8[k] = pack8();
      obs4[k] = pack4();
      chk($sformatf("aw8 c%0d", k), 32'(obs8[k]), 32'(exp8[k]));
      chk($sformatf("aw4 c%0d", k), 32'(obs4[k]), 32'(exp4[k]));
      CARRY = cy[k];
      ZERO = zr[k];
      @(negedge clk);
    end
  endtask

  function automatic logic [7:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 4'h9 && $urandom_range(0, 3) != 0) op = 4'h1;
    return {op, 4'($urandom)};
  endfunction

  task automatic set_flags(input logic c, input logic z);
    for (int i = 0; i < NMAX; i++) begin
      cy[i] = c;
      zr[i] = z;
    end
  endtask

  task automatic clear_roms();
    for (int i = 0; i < 256; i++) rom8[i] = 8'h00;
    for (int i = 0; i < 16; i++) rom4[i] = 8'h00;
  endtask

  initial begin
    clear_roms();
    set_flags(1'b0, 1'b0);

    // Straight-line program: LIT A, ADD 3, OUT, HALT
    rom8[0] = 8'h1A; rom8[1] = 8'h33; rom8[2] = 8'h50; rom8[3] = 8'h90;
    for (int i = 0; i < 16; i++) rom4[i] = rom8[i];
    apply(16);
    chk("sl_lit", 32'(obs8[2][17:8]), 32'(10'b0_1_1_010_1010));
    chk("sl_gap", 32'(obs8[3][17:15]), 32'd0);
    chk("sl_add", 32'(obs8[5][17:8]), 32'(10'b0_1_1_011_0011));
    chk("sl_out", 32'(obs8[8][17:8]), 32'(10'b1_0_0_000_0000));
    chk("sl_run", 32'(obs8[10][18]), 32'd0);
    chk("sl_halt", 32'(obs8[11][18]), 32'd1);
    chk("sl_stay", 32'(obs8[15][18]), 32'd1);

    // Conditional jumps: JC 5 ; JNZ 0
    clear_roms();
    rom8[0] = 8'h70; rom8[1] = 8'h05; rom8[2] = 8'h80; rom8[3] = 8'h00;
    for (int i = 0; i < 16; i++) rom4[i] = rom8[i];
    apply(14);
    chk("jc_nt", 32'(obs8[4][7:0]), 32'd2);
    chk("jnz_t", 32'(obs8[8][7:0]), 32'd0);
    chk("jnz_t4", 32'(obs4[8][7:0]), 32'd0);
    set_flags(1'b1, 1'b1);
    apply(14);
    chk("jc_t", 32'(obs8[4][7:0]), 32'd5);

    // Wrap-around: NOP everywhere; AW=4 has JMP at 15 with wide target
    clear_roms();
    set_flags(1'b0, 1'b0);
    rom4[15] = 8'h60;
    rom4[0] = 8'hF7;
    apply(780);
    chk("wrap4_15", 32'(obs4[45][7:0]), 32'd15);
    chk("wrap4_ja", 32'(obs4[47][7:0]), 32'd0);
    chk("wrap4_tg", 32'(obs4[49][7:0]), 32'd7);
    chk("wrap8_ff", 32'(obs8[765][7:0]), 32'd255);
    chk("wrap8_00", 32'(obs8[768][7:0]), 32'd0);

    // Reset asserted while in JLOAD of a taken JMP
    clear_roms();
    rom8[0] = 8'h60; rom8[1] = 8'h05;
    rom4[0] = 8'h60; rom4[1] = 8'h05;
    apply(3);
    resetA = 1'b0;
    @(negedge clk);
    chk("midjump8", 32'(pack8()), 32'd0);
    chk("midjump4", 32'(pack4()), 32'd0);

    // Randomized programs and flag sequences
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 256; i++) rom8[i] = rand_instr();
      for (int i = 0; i < 16; i++) rom4[i] = rand_instr();
      for (int i = 0; i < NMAX; i++) begin
        cy[i] = 1'($urandom);
        zr[i] = 1'($urandom);
      end
      apply(120);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
